ten_neuron_bank: RTL and testbench
==================================

Name: ten_neuron_bank

Overview:
- Computes ten fully-connected neurons of one hidden layer, in parallel, over a 62-element input vector.
- Each neuron evaluates bias + Σ(weight·input) sequentially, one input per clock.
- Output is passed through ReLU with saturation.
- Two instances (outputs 0–9 and 10–19) form the 20-neuron hidden layer. All operands are 8-bit sign-magnitude (bit7 = sign, bits6:0 = magnitude, scale 1/128).

Parameters:
- N_IN, 62, number of inputs per neuron
- N_NEU, 10, number of neurons in the bank
- W, 8, operand/result width (sign-magnitude)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- received  input  1  consumer acknowledge; clears ready
- start  input  1  begin computation (sampled when idle)
- biases  input  80  bias n at bits [8n +: 8] (ascending [0:79]; bit 8n is sign)
- data  input  496  input k at bits [8k +: 8]
- weights  input  4960  weight(n,k) at bits [8(62n+k) +: 8]
- out  output  80  post-ReLU result of neuron n at [8n +: 8]
- notused_out  output  80  pre-activation saturated result of neuron n at [8n +: 8]
- ready  output  1  results valid

Behaviour:
- Reset (rst_n=0, async): state IDLE; counter=0; accumulators=0; out=0; notused_out=0; ready=0.
- States: IDLE, MAC, DONE.
- IDLE, edge with start=1:
  - acc[n] = sign-extended bias[n] magnitude << 7, negated if the bias sign bit is set.
  - counter=0; go to MAC.
  - ready cleared.
- MAC, edges 1..62:
  - acc[n] += product(weight(n,k), data[k]) for k = counter; counter++.
  - Product: magnitude = 7b×7b = 14b unsigned; sign = XOR of the sign bits; added in two's complement.
  - Accumulator is ≥21 bits signed; it never overflows.
  - After k=61, go to DONE.
- DONE, one edge (edge 63 after the start edge):
  - r = sign(acc) · floor(|acc| / 128), i.e. truncation toward zero.
  - Saturate |r| to 127.
  - notused_out[n] = sign-magnitude of saturated r; magnitude 0 is always encoded 0x00.
  - out[n] = 0x00 if r<0, else {0, |r|}.
  - ready=1; return to IDLE.
- Latency: ready rises 63 clocks after the edge that samples start.
- ready stays 1 until the first edge with received=1, or a new start is accepted; it then clears on that edge.
- out and notused_out hold their values until the next DONE or reset.
- start while in MAC/DONE: ignored.
- start and received high together in IDLE: the new computation starts and ready clears.
- data, weights and biases must be held stable from the start edge through DONE; they are sampled combinationally each MAC cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0; a subsequent start computes correctly.

Test Plan:
- Zero inputs: data all 0x00, bias0=0x10, bias1=0x90, others 0, start pulse.
  - ready high exactly 63 clocks later.
  - out0=0x10, notused0=0x10; out1=0x00, notused1=0x90.
- Positive MAC: data all 0x40, neuron2 weights all 0x01, bias 0.
  - Sum = 62·64 = 3968, so out2=0x1F and notused2=0x1F.
- Negative MAC: neuron3 weights all 0x81, data 0x40.
  - out3=0x00, notused3=0x9F.
- Saturation: data all 0x7F.
  - Neuron4 weights 0x7F → out4=0x7F, notused4=0x7F.
  - Neuron5 weights 0xFF → out5=0x00, notused5=0xFF.
- Handshake:
  - After ready=1, assert received for 1 clk → ready=0 next edge while out holds.
  - A start pulse issued mid-MAC is ignored; ready still rises at the original cycle 63.
- Reset mid-op: assert rst_n=0 at MAC cycle 30 → ready=0 and out=0 immediately.
  - Release, then start the zero-input case → correct results after 63 clocks.

Source files
------------

// File: rtl/ten_neuron_bank.sv
// Ten sign-magnitude neurons evaluated in parallel over a 62-element input vector,
// one multiply-accumulate per clock, followed by saturating ReLU.
//   state | meaning
//   IDLE  | waiting for start; results and ready hold
//   MAC   | acc[n] += weight(n,k) * data[k], k = counter
//   DONE  | scale by 1/128, saturate, register outputs, raise ready
module ten_neuron_bank #(
  parameter int N_IN  = 62,
  parameter int N_NEU = 10,
  parameter int W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      received,
  input  logic                      start,
  input  logic [W*N_NEU-1:0]        biases,
  input  logic [W*N_IN-1:0]         data,
  input  logic [W*N_IN*N_NEU-1:0]   weights,
  output logic [W*N_NEU-1:0]        out,
  output logic [W*N_NEU-1:0]        notused_out,
  output logic                      ready
);

  localparam int MAG_W  = W - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int ACC_W  = PROD_W + $clog2(N_IN + 1) + 2;
  localparam int CNT_W  = $clog2(N_IN);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          counter;
  logic signed [ACC_W-1:0]   acc       [N_NEU];
  logic signed [ACC_W-1:0]   bias_term [N_NEU];
  logic signed [ACC_W-1:0]   prod_term [N_NEU];
  logic [W-1:0]              bias_sm   [N_NEU];
  logic [2*W-1:0]            act       [N_NEU];

  function automatic logic signed [ACC_W-1:0] sm_to_acc(input logic sign,
                                                        input logic [PROD_W-1:0] mag);
    logic signed [ACC_W-1:0] v;
    v = signed'(ACC_W'(mag));
    return sign ? -v : v;
  endfunction

  // Returns {relu byte, pre-activation sign-magnitude byte}; truncates toward zero.
  function automatic logic [2*W-1:0] activate(input logic signed [ACC_W-1:0] a);
    logic             neg;
    logic [ACC_W-1:0] mag;
    logic [MAG_W-1:0] m;
    neg = a[ACC_W-1];
    mag = neg ? unsigned'(-a) : unsigned'(a);
    m   = (|mag[ACC_W-1:PROD_W]) ? '1 : mag[PROD_W-1:MAG_W];
    return {neg ? W'(0) : {1'b0, m}, (m == '0) ? W'(0) : {neg, m}};
  endfunction

  always_comb begin
    logic [W-1:0] w_sel;
    logic [W-1:0] d_sel;
    w_sel = '0;
    d_sel = '0;
    for (int n = 0; n < N_NEU; n++) begin
      bias_sm[n]   = '0;
      bias_term[n] = '0;
      prod_term[n] = '0;
      act[n]       = '0;
    end
    for (int n = 0; n < N_NEU; n++) begin
      // The bias bus numbers bits so that bit W*n carries the sign.
      for (int i = 0; i < W; i++) bias_sm[n][W-1-i] = biases[W*n+i];
      bias_term[n] = sm_to_acc(bias_sm[n][W-1], {bias_sm[n][MAG_W-1:0], {MAG_W{1'b0}}});
      w_sel = weights[W*(N_IN*n + int'(counter)) +: W];
      d_sel = data[W*int'(counter) +: W];
      prod_term[n] = sm_to_acc(w_sel[W-1] ^ d_sel[W-1],
                               PROD_W'(w_sel[MAG_W-1:0]) * PROD_W'(d_sel[MAG_W-1:0]));
      act[n] = activate(acc[n]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= '0;
      out         <= '0;
      notused_out <= '0;
      ready       <= 1'b0;
      for (int n = 0; n < N_NEU; n++) acc[n] <= '0;
    end else begin
      if (received) ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int n = 0; n < N_NEU; n++) acc[n] <= bias_term[n];
            counter <= '0;
            ready   <= 1'b0;
            state   <= MAC;
          end
        end
        MAC: begin
          for (int n = 0; n < N_NEU; n++) acc[n] <= acc[n] + prod_term[n];
          if (counter == CNT_W'(N_IN - 1)) begin
            counter <= '0;
            state   <= DONE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          for (int n = 0; n < N_NEU; n++) begin
            out[W*n +: W]         <= act[n][2*W-1:W];
            notused_out[W*n +: W] <= act[n][W-1:0];
          end
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ten_neuron_bank.sv
// Directed-vector bench for ten_neuron_bank; expected results are queued at start
// and checked by an independent monitor when ready rises.
module tb_ten_neuron_bank;
  localparam int N_IN = 62, N_NEU = 10, W = 8;

  logic clk = 1'b0;
  logic rst_n, received, start;
  logic [W*N_NEU-1:0]      biases;
  logic [W*N_IN-1:0]       data;
  logic [W*N_IN*N_NEU-1:0] weights;
  logic [W*N_NEU-1:0]      out, notused_out;
  logic                    ready;

  typedef struct {
    logic [79:0] o;
    logic [79:0] nu;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks = 0, errors = 0, cyc = 0;
  logic ready_q = 1'b0;
  logic [79:0] o1, nu1, oa, nua, ob, nub;

  ten_neuron_bank #(.N_IN(N_IN), .N_NEU(N_NEU), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .received(received), .start(start),
    .biases(biases), .data(data), .weights(weights),
    .out(out), .notused_out(notused_out), .ready(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (ready && !ready_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending result");
      end else begin
        e_mon = sb.pop_front();
        check("out", out, e_mon.o);
        check("notused_out", notused_out, e_mon.nu);
        check("latency", 80'(cyc - e_mon.edge_no), 80'd63);
      end
    end
    ready_q <= ready;
  end

  task automatic clear_vectors();
    biases = '0; data = '0; weights = '0;
  endtask

  // Bit W*n of the bias bus is the sign bit.
  task automatic set_bias(input int n, input logic [7:0] b);
    for (int i = 0; i < W; i++) biases[W*n+i] = b[7-i];
  endtask

  task automatic set_data_all(input logic [7:0] b);
    for (int k = 0; k < N_IN; k++) data[W*k +: W] = b;
  endtask

  task automatic set_weights_row(input int n, input logic [7:0] b);
    for (int k = 0; k < N_IN; k++) weights[W*(N_IN*n+k) +: W] = b;
  endtask

  task automatic start_run(input bit push, input logic [79:0] o, input logic [79:0] nu);
    @(negedge clk);
    start = 1'b1;
    if (push) sb.push_back('{o, nu, cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) return;
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
  endtask

  task automatic load_zero_case();
    clear_vectors();
    set_bias(0, 8'h10);
    set_bias(1, 8'h90);
  endtask

  task automatic load_case_a();
    clear_vectors();
    set_data_all(8'h40);
    set_weights_row(2, 8'h01);
    set_weights_row(3, 8'h81);
  endtask

  task automatic load_case_b();
    clear_vectors();
    set_data_all(8'h7F);
    set_weights_row(4, 8'h7F);
    set_weights_row(5, 8'hFF);
    set_bias(6, 8'h90);
    set_bias(7, 8'h81);
    set_weights_row(7, 8'h01);
    set_bias(8, 8'h01);
    set_weights_row(8, 8'h81);
    weights[W*(N_IN*9) +: W] = 8'h81;
  endtask

  initial begin
    // zero-input case: +16 and -16 biases
    o1 = '0; nu1 = '0;
    o1[7:0] = 8'h10; nu1[7:0] = 8'h10; nu1[15:8] = 8'h90;
    // 62*64 = 3968 -> 31
    oa = '0; nua = '0;
    oa[23:16] = 8'h1F; nua[23:16] = 8'h1F; nua[31:24] = 8'h9F;
    // saturation, bias mixing and truncation-to-zero cases
    ob = '0; nub = '0;
    ob[39:32] = 8'h7F; nub[39:32] = 8'h7F;
    nub[47:40] = 8'hFF;
    nub[55:48] = 8'h90;
    ob[63:56] = 8'h3C; nub[63:56] = 8'h3C;
    nub[71:64] = 8'hBC;

    rst_n = 1'b0; start = 1'b0; received = 1'b0;
    clear_vectors();
    #1;
    check("reset_out", out, '0);
    check("reset_notused", notused_out, '0);
    check("reset_ready", 80'(ready), 80'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load_zero_case();
    start_run(1'b1, o1, nu1);
    wait_ready();

    load_case_a();
    start_run(1'b1, oa, nua);
    wait_ready();

    load_case_b();
    start_run(1'b1, ob, nub);
    wait_ready();
    repeat (3) @(negedge clk);
    check("ready_hold", 80'(ready), 80'd1);
    received = 1'b1;
    @(posedge clk);
    #1;
    received = 1'b0;
    check("ready_clear", 80'(ready), 80'd0);
    check("out_hold", out, ob);
    check("notused_hold", notused_out, nub);

    // start pulse during MAC must not restart the computation
    load_case_a();
    start_run(1'b1, oa, nua);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready();

    // reset during MAC, then a clean restart
    load_zero_case();
    start_run(1'b0, '0, '0);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ready", 80'(ready), 80'd0);
    check("midreset_out", out, '0);
    check("midreset_notused", notused_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(1'b1, o1, nu1);
    wait_ready();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 80'(sb.size()), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
